chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
- Multi-cycle N-bit adder/subtractor. Each operation adds one CHUNK-bit slice per clock, least-significant slice first, and carries the value between slices in a register.
- Successor to the combinational ripple adder. Adds a runtime add/sub mode, a signed-overflow flag and a valid/ready handshake on input and output.
- Trades latency for area. Used where a WIDTH-bit carry chain does not meet timing or the area budget.

Parameters:
- WIDTH, 16, operand and result width in bits. Must satisfy WIDTH >= 2.
- CHUNK, 4, bits processed per cycle. WIDTH % CHUNK must equal 0; elaboration fails otherwise.
- NCHUNK, WIDTH/CHUNK, derived localparam. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; when sub=1, 1 means no borrow (A >= B unsigned)
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low, sampled on the rising clk edge.
- Reset values: state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, chunk index=0, carry reg=0. in_ready=1 in the cycle after reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid=1 at an edge, register a, the effective b (~b if sub), and carry0 (sub ? 1 : cin). Clear the index, then go to RUN.
  - RUN: in_ready=0. Each cycle, slice k = operand bits [k*CHUNK +: CHUNK] plus the carry reg. Write the slice sum into sum[k*CHUNK +: CHUNK] and update the carry reg.
  - RUN, final slice (k = NCHUNK-1): additionally latch cout = carry out and ovf = carry-into-MSB XOR carry-out-of-MSB. Set out_valid=1 and go to DONE.
  - DONE: out_valid=1; sum, cout and ovf held stable. When out_ready=1 at an edge, clear out_valid and go to IDLE. in_ready=0 throughout DONE.
- Latency: out_valid rises exactly NCHUNK edges after the accepting edge.
- Throughput: one operation per NCHUNK+2 cycles with out_ready tied high. No overlap between operations.
- sum is undefined while in RUN; only the DONE value is architectural. An implementation may clear sum on accept.
- Inputs a, b, cin and sub changing after the accept edge have no effect on the operation in flight.
- in_valid asserted outside IDLE is ignored. The request is not queued; the producer keeps in_valid high until it sees in_ready.
- out_ready while not in DONE is ignored.
- Reset asserted mid-RUN or in DONE: next edge returns all state to the reset values. The partial result is discarded and no out_valid pulse occurs.
- Carry handling: the carry reg is CHUNK+1-bit arithmetic truncated to the top bit. No combinational path crosses a chunk boundary.

Optional Feature:
- Macro: CHUNKED_SERIAL_ADDER_SAT_EN.
- Defined: in DONE, if ovf=1, sum is replaced with signed saturation.
  - Positive overflow (operand sign bits both 0 after B inversion) gives 0111…1.
  - Negative overflow gives 1000…0.
  - ovf and cout still report the raw values.
- Not defined: sum is the wrapped modulo-2^WIDTH result. No saturation logic is present.

Decomposition:
- Package chunked_adder_pkg:
  - state enum type (IDLE, RUN, DONE)
  - function computing signed saturation constants for a given width
- Sub-module chunk_adder (combinational, CHUNK-bit ripple add of x, y, ci):
  - outputs the CHUNK-bit sum, the carry out, and the carry into the top bit (needed for ovf)
  - built as a chain of the team's single-bit full adder cells
- The top level holds the FSM, the operand, index and carry registers, and the result registers.

Test Plan (WIDTH=16, CHUNK=4):
- Add with internal carry: a=0x00FF, b=0x0001, cin=0, sub=0 -> sum=0x0100, cout=0, ovf=0. out_valid exactly 4 edges after accept; in_ready=0 throughout RUN and DONE.
- Unsigned wrap: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
- Add with carry-in: a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0, ovf=0.
- Signed positive overflow: a=0x7FFF, b=0x0001, add -> ovf=1, cout=0. sum=0x8000 without SAT_EN; sum=0x7FFF with SAT_EN.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0.
- Subtract, negative overflow: a=0x8000, b=0x0001, sub=1 -> ovf=1, cout=1. sum=0x7FFF without SAT_EN; sum=0x8000 with SAT_EN.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum/cout/ovf/out_valid stable and in_ready=0; the 4th-cycle out_ready=1 returns to IDLE.
- Reset mid-operation: assert rst_n=0 at RUN slice 2 -> next edge out_valid=0, in_ready=1. The following request (0x1234+0x1111) completes normally with 0x2345.

Source files
------------

// File: rtl/chunked_adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
package chunked_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned SAT_MAXW = 64;

   // Signed saturation constant for a w-bit result: 100..0 when neg, else 011..1.
   function automatic logic [SAT_MAXW-1:0] sat_const(input int unsigned w, input logic neg);
      logic [SAT_MAXW-1:0] msb;
      msb = SAT_MAXW'(1) << (w - 1);
      return neg ? msb : (msb - SAT_MAXW'(1));
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells.
// Exposes the carry into the top bit so the caller can form signed overflow.
module chunk_adder #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_top
);

   logic [CHUNK:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      full_adder u_fa (
         .a  (x[i]),
         .b  (y[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign co    = c[CHUNK];
   assign c_top = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, one CHUNK-bit slice per clock, LSB slice first.
// Optional signed saturation of the result: define CHUNKED_SERIAL_ADDER_SAT_EN.
module chunked_serial_adder
   import chunked_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if ((WIDTH < 2) || (CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
      $error("chunked_serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [IW-1:0]    idx;

   logic [CHUNK-1:0] slice_s;
   logic             slice_co;
   logic             slice_ctop;
   logic             last_slice;

   // Operands shift right each cycle so the active slice is always the low CHUNK bits.
   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .x     (op_a[CHUNK-1:0]),
      .y     (op_b[CHUNK-1:0]),
      .ci    (carry),
      .s     (slice_s),
      .co    (slice_co),
      .c_top (slice_ctop)
   );

   assign last_slice = (idx == IW'(NCHUNK - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         idx       <= '0;
         carry     <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a     <= a;
                  op_b     <= sub ? ~b : b;
                  carry    <= sub ? 1'b1 : cin;
                  idx      <= '0;
                  sum      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end

            RUN: begin
               sum[int'(idx)*CHUNK +: CHUNK] <= slice_s;
               carry <= slice_co;
               op_a  <= op_a >> CHUNK;
               op_b  <= op_b >> CHUNK;
               idx   <= idx + IW'(1);
               if (last_slice) begin
                  cout      <= slice_co;
                  ovf       <= slice_ctop ^ slice_co;
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef CHUNKED_SERIAL_ADDER_SAT_EN
                  // On overflow both operand signs agree; op_a's top bit gives the direction.
                  if (slice_ctop ^ slice_co) begin
                     sum <= WIDTH'(sat_const(WIDTH, op_a[CHUNK-1]));
                  end
`endif
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder (WIDTH=16, CHUNK=4) with directed vectors.
// Honours CHUNKED_SERIAL_ADDER_SAT_EN for the overflow cases.
module tb_chunked_serial_adder;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned CHUNK  = 4;
   localparam int unsigned NCHUNK = WIDTH / CHUNK;

`ifdef CHUNKED_SERIAL_ADDER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      string            name;
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: compare every handshaked result against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 32'(sum), 32'hDEAD_BEEF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_sum"},  32'(sum),  32'(e.sum));
            check({e.name, "_cout"}, 32'(cout), 32'(e.cout));
            check({e.name, "_ovf"},  32'(ovf),  32'(e.ovf));
         end
      end
   end

   task automatic wait_ready(input string nm);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) check({nm, "_ready_timeout"}, 32'(in_ready), 32'd1);
   endtask

   // Issue one request, check latency and in_ready, optionally stall the result for `hold` cycles.
   task automatic run_op(input string nm, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tcin, input logic tsub, input logic [WIDTH-1:0] es,
                         input logic ec, input logic eo, input int hold);
      wait_ready(nm);
      a = ta;  b = tb_;  cin = tcin;  sub = tsub;  in_valid = 1'b1;
      sb.push_back('{nm, es, ec, eo});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = WIDTH'($urandom);  b = WIDTH'($urandom);  cin = ~tcin;  sub = ~tsub;
      for (int k = 0; k < int'(NCHUNK); k++) begin
         check({nm, "_in_ready_run"},  32'(in_ready),  32'd0);
         check({nm, "_out_valid_run"}, 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      check({nm, "_latency"}, 32'(out_valid), 32'd1);
      for (int h = 0; h < hold; h++) begin
         check({nm, "_in_ready_done"}, 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         check({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({nm, "_hold_sum"},   32'(sum),       32'(es));
         check({nm, "_hold_cout"},  32'(cout),      32'(ec));
         check({nm, "_hold_ovf"},   32'(ovf),       32'(eo));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({nm, "_valid_clear"}, 32'(out_valid), 32'd0);
      check({nm, "_idle_ready"},  32'(in_ready),  32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum",       32'(sum),       32'd0);
      check("rst_cout",      32'(cout),      32'd0);
      check("rst_ovf",       32'(ovf),       32'd0);
      rst_n = 1'b1;
      // out_ready outside DONE must be ignored
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("idle_out_ready_ignored", 32'(out_valid), 32'd0);

      run_op("add_carry",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
      run_op("wrap",       16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      run_op("cin",        16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 0);
      run_op("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 0);
      run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
      run_op("neg_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 0);
      run_op("sub_equal",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
      run_op("backpress",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 3);

      // Reset during RUN: abandon the operation, no result expected.
      wait_ready("rst_mid");
      a = 16'hAAAA;  b = 16'h5555;  cin = 1'b0;  sub = 1'b0;  in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mid_running", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check("rst_mid_in_ready",  32'(in_ready),  32'd1);
      repeat (NCHUNK + 1) begin
         @(posedge clk);
         #1;
         check("rst_mid_no_pulse", 32'(out_valid), 32'd0);
      end

      run_op("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 0);

      @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
